// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit and its buffers.
//   NOP_INSTR            : instruction word shown when nothing is buffered
//   DEFAULT_RESET_VECTOR : default PC after reset
//   fetch_entry_t        : {instruction word, PC of that word}
//   cnt_width()          : width of a counter that must reach 0..depth
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetch_entry_t.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_push/i_push_data : write an entry (honoured when not full, or when full
//                        with a simultaneous pop)
//   i_pop          : drop the head entry (ignored when empty)
//   i_flush        : empty the FIFO; overrides push and pop
//   o_count        : number of valid entries
//   o_head         : head entry (undefined when o_count == 0)
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_push,
  input  fetch_entry_t                  i_push_data,
  input  logic                          i_pop,
  input  logic                          i_flush,
  output logic [cnt_width(DEPTH)-1:0]   o_count,
  output fetch_entry_t                  o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = cnt_width(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_full;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0) && !i_flush;
  assign w_do_push = i_push && (!w_full || w_do_pop) && !i_flush;

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues in-order word requests over a
// req/gnt/rvalid memory interface, buffers returned words and hands them to
// decode with a valid/ready handshake. Redirects flush the buffer and drop
// responses still in flight.
//   Clk_i, Reset_ni              : clock, async active-low reset
//   Imem_Req_o, Imem_Addr_o      : request valid / word address
//   Imem_Gnt_i                   : request accepted
//   Imem_Rvalid_i, Imem_Rdata_i  : in-order response
//   Redirect_i, Redirect_Pc_i    : branch/jump redirect and target
//   Valid_o, Ready_i             : decode handshake
//   Instruction_o, Pc_o          : head instruction and its PC
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic        Clk_i,
  input  logic        Reset_ni,
  output logic        Imem_Req_o,
  output logic [31:0] Imem_Addr_o,
  input  logic        Imem_Gnt_i,
  input  logic        Imem_Rvalid_i,
  input  logic [31:0] Imem_Rdata_i,
  input  logic        Redirect_i,
  input  logic [31:0] Redirect_Pc_i,
  output logic        Valid_o,
  input  logic        Ready_i,
  output logic [31:0] Instruction_o,
  output logic [31:0] Pc_o
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  logic [31:0]      r_pc;
  logic [31:0]      r_pc_hold;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop_cnt;

  logic [CNT_W-1:0] w_buf_count;
  logic [CNT_W-1:0] w_tag_count;
  logic [CNT_W:0]   w_inflight;
  fetch_entry_t     w_tag_head;
  fetch_entry_t     w_buf_head;
  fetch_entry_t     w_tag_push_data;
  fetch_entry_t     w_buf_push_data;
  logic             w_req;
  logic             w_grant;
  logic             w_drop;
  logic             w_accept;
  logic             w_pop;
  logic             w_unused_tag_instr;

  // Credit rule: buffered plus in-flight never exceeds the buffer depth, so
  // every response has a slot waiting. Reset gates the request so it drops
  // the moment reset asserts.
  assign w_inflight = {1'b0, w_buf_count} + {1'b0, r_outstanding};
  assign w_req      = (w_inflight < (CNT_W+1)'(FIFO_DEPTH)) && !Redirect_i && Reset_ni;
  assign w_grant    = w_req && Imem_Gnt_i;

  // Responses owed to requests issued before the last redirect are dropped.
  assign w_drop   = Imem_Rvalid_i && (r_drop_cnt != '0);
  assign w_accept = Imem_Rvalid_i && (r_drop_cnt == '0) && !Redirect_i;

  assign Valid_o = (w_buf_count != '0);
  assign w_pop   = Valid_o && Ready_i && !Redirect_i;

  // Tag FIFO only needs the PC; the instruction field is a fixed filler.
  assign w_tag_push_data.instr = NOP_INSTR;
  assign w_tag_push_data.pc    = r_pc;
  assign w_unused_tag_instr    = ^w_tag_head.instr;

  assign w_buf_push_data.instr = Imem_Rdata_i;
  assign w_buf_push_data.pc    = w_tag_head.pc;

  fetch_buffer #(
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .i_clk       (Clk_i),
    .i_rst_n     (Reset_ni),
    .i_push      (w_grant),
    .i_push_data (w_tag_push_data),
    .i_pop       (w_accept),
    .i_flush     (Redirect_i),
    .o_count     (w_tag_count),
    .o_head      (w_tag_head)
  );

  fetch_buffer #(
    .DEPTH (FIFO_DEPTH)
  ) u_instr_buf (
    .i_clk       (Clk_i),
    .i_rst_n     (Reset_ni),
    .i_push      (w_accept),
    .i_push_data (w_buf_push_data),
    .i_pop       (w_pop),
    .i_flush     (Redirect_i),
    .o_count     (w_buf_count),
    .o_head      (w_buf_head)
  );

  always_ff @(posedge Clk_i or negedge Reset_ni) begin
    if (!Reset_ni) begin
      r_pc          <= RESET_VECTOR;
      r_pc_hold     <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      // Remembers the last head PC so Pc_o holds steady once the buffer empties.
      if (Valid_o) begin
        r_pc_hold <= w_buf_head.pc;
      end

      case ({w_grant, Imem_Rvalid_i})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase

      if (Redirect_i) begin
        r_pc       <= {Redirect_Pc_i[31:2], 2'b00};
        r_drop_cnt <= r_outstanding - CNT_W'(Imem_Rvalid_i);
      end else begin
        if (w_grant) begin
          r_pc <= r_pc + 32'd4;
        end
        if (w_drop) begin
          r_drop_cnt <= r_drop_cnt - CNT_W'(1);
        end
      end
    end
  end

  assign Imem_Req_o    = w_req;
  assign Imem_Addr_o   = r_pc;
  assign Instruction_o = Valid_o ? w_buf_head.instr : NOP_INSTR;
  assign Pc_o          = Valid_o ? w_buf_head.pc    : r_pc_hold;

  always_ff @(posedge Clk_i) begin
    if (Reset_ni) begin
      assert (r_outstanding <= CNT_W'(FIFO_DEPTH));
      assert (w_inflight <= (CNT_W+1)'(FIFO_DEPTH));
      assert (!(Imem_Rvalid_i && (r_outstanding == '0)));
      assert (w_tag_count <= r_outstanding);
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic        Clk_i = 1'b0;
  logic        Reset_ni = 1'b0;
  logic        Imem_Req_o;
  logic [31:0] Imem_Addr_o;
  logic        Imem_Gnt_i = 1'b0;
  logic        Imem_Rvalid_i = 1'b0;
  logic [31:0] Imem_Rdata_i = '0;
  logic        Redirect_i = 1'b0;
  logic [31:0] Redirect_Pc_i = '0;
  logic        Valid_o;
  logic        Ready_i = 1'b0;
  logic [31:0] Instruction_o;
  logic [31:0] Pc_o;

  always #5 Clk_i = ~Clk_i;

  instruction_fetch_unit #(
    .RESET_VECTOR (RV),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .Clk_i         (Clk_i),
    .Reset_ni      (Reset_ni),
    .Imem_Req_o    (Imem_Req_o),
    .Imem_Addr_o   (Imem_Addr_o),
    .Imem_Gnt_i    (Imem_Gnt_i),
    .Imem_Rvalid_i (Imem_Rvalid_i),
    .Imem_Rdata_i  (Imem_Rdata_i),
    .Redirect_i    (Redirect_i),
    .Redirect_Pc_i (Redirect_Pc_i),
    .Valid_o       (Valid_o),
    .Ready_i       (Ready_i),
    .Instruction_o (Instruction_o),
    .Pc_o          (Pc_o)
  );

  // Memory side: granted requests waiting for a response, tagged with the
  // fetch epoch (bumped by every redirect/reset) they belong to.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          gcyc;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] exp_buf[$];
  int          epoch = 0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pops = 0;
  logic [31:0] req_pc = RV;
  logic [31:0] last_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int stale_count();
    int n = 0;
    foreach (mq[i]) if (mq[i].epoch != epoch) n++;
    return n;
  endfunction

  task automatic step(input bit redir, input logic [31:0] tgt, input bit rdy,
                      input bit gnt, input bit rsp);
    bit    rv;
    bit    exp_req;
    bit    do_pop;
    mreq_t e;
    @(negedge Clk_i);
    chk("valid", {31'b0, Valid_o}, {31'b0, exp_buf.size() != 0});
    if (exp_buf.size() != 0) begin
      chk("pc", Pc_o, exp_buf[0]);
      chk("instr", Instruction_o, mem_word(exp_buf[0]));
      last_pc = exp_buf[0];
    end else begin
      chk("instr_nop", Instruction_o, NOP_INSTR);
      chk("pc_hold", Pc_o, last_pc);
    end
    chk("drop_cnt", 32'(dut.r_drop_cnt), stale_count());

    rv = rsp && (mq.size() != 0) && (mq[0].gcyc < cyc);
    Redirect_i    = redir;
    Redirect_Pc_i = tgt;
    Ready_i       = rdy;
    Imem_Gnt_i    = gnt;
    Imem_Rvalid_i = rv;
    Imem_Rdata_i  = rv ? mem_word(mq[0].addr) : $urandom;
    #1;
    exp_req = ((exp_buf.size() + mq.size()) < DEPTH) && !redir;
    chk("req", {31'b0, Imem_Req_o}, {31'b0, exp_req});
    if (exp_req) chk("addr", Imem_Addr_o, req_pc);

    do_pop = rdy && !redir && (exp_buf.size() != 0);
    if (rv) begin
      e = mq.pop_front();
      if (!redir && e.epoch == epoch) exp_buf.push_back(e.addr);
    end
    if (do_pop) begin
      void'(exp_buf.pop_front());
      n_pops++;
    end
    if (redir) begin
      exp_buf.delete();
      epoch++;
      req_pc = {tgt[31:2], 2'b00};
    end
    if (Imem_Req_o && gnt) begin
      e.addr  = Imem_Addr_o;
      e.epoch = epoch;
      e.gcyc  = cyc;
      mq.push_back(e);
      req_pc = req_pc + 32'd4;
    end
    cyc++;
  endtask

  task automatic async_reset();
    @(negedge Clk_i);
    #2;
    Reset_ni      = 1'b0;
    Redirect_i    = 1'b0;
    Ready_i       = 1'b0;
    Imem_Gnt_i    = 1'b0;
    Imem_Rvalid_i = 1'b0;
    #1;
    chk("arst_valid", {31'b0, Valid_o}, 32'd0);
    chk("arst_req", {31'b0, Imem_Req_o}, 32'd0);
    chk("arst_pc", Pc_o, 32'd0);
    mq.delete();
    exp_buf.delete();
    epoch++;
    req_pc  = RV;
    last_pc = '0;
    @(negedge Clk_i);
    #2;
    Reset_ni = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge Clk_i);
    #1;
    chk("rst_req", {31'b0, Imem_Req_o}, 32'd0);
    chk("rst_valid", {31'b0, Valid_o}, 32'd0);
    chk("rst_instr", Instruction_o, NOP_INSTR);
    chk("rst_pc", Pc_o, 32'd0);
    @(negedge Clk_i);
    #2;
    Reset_ni = 1'b1;

    // streaming: grant every cycle, 1-cycle response, decode always ready
    repeat (6) step(0, '0, 1, 1, 1);
    // decode stalls: requests stop once the credits are used up
    repeat (6) step(0, '0, 0, 1, 1);
    step(0, '0, 1, 1, 1);
    repeat (3) step(0, '0, 0, 1, 1);
    // grant withheld: request and address held
    repeat (3) step(0, '0, 1, 0, 1);
    step(0, '0, 1, 1, 1);
    // drain, then redirect with two requests outstanding
    repeat (4) step(0, '0, 1, 0, 1);
    repeat (2) step(0, '0, 1, 1, 0);
    step(1, 32'h0000_0100, 1, 1, 0);
    repeat (8) step(0, '0, 1, 1, 1);
    // redirect to an unaligned target coinciding with a response
    repeat (2) step(0, '0, 1, 1, 0);
    step(1, 32'h0000_0203, 1, 1, 1);
    repeat (8) step(0, '0, 1, 1, 1);

    // randomized traffic with an asynchronous reset in the middle
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) async_reset();
      step($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
    end
    chk("progress", {31'b0, n_pops > 100}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
